// File: rtl/tc_operand_stream_tx.sv
// Operand-SRAM to AXI-Stream transmitter feeding one tensor-core operand port.
// Reads num_beats consecutive words into a 2-entry FIFO and streams them out with tlast.
module tc_operand_stream_tx #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_beats,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  issued;
    logic [CNT_WIDTH-1:0]  sent;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic                  pop;
    logic                  push;
    logic                  last_beat;
    logic                  abort_run;
    logic [2:0]            occupancy;
    logic                  rd_req;

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_beat     = (sent == num_q - CNT_WIDTH'(1));
    assign m_axis_tlast  = m_axis_tvalid && last_beat;

    // A final-beat handshake wins over abort so the transfer ends with its tlast delivered.
    assign abort_run = abort && (state == RUN) && !(pop && last_beat);
    assign push      = inflight && !abort_run;

    // Words held or on their way back; a read is allowed if a slot frees by the response cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight);
    assign rd_req    = (state == RUN) && !abort_run && (issued < num_q)
                       && (occupancy < 3'd2 + 3'(pop));

    assign mem_rd_en   = rd_req;
    assign mem_rd_addr = base_q + ADDR_WIDTH'(issued);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_run || (pop && last_beat)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= rd_req;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                num_q  <= num_beats;
                issued <= '0;
                sent   <= '0;
            end else if (state == RUN) begin
                if (rd_req) begin
                    issued <= issued + CNT_WIDTH'(1);
                end
                if (pop) begin
                    sent <= sent + CNT_WIDTH'(1);
                end
            end
        end
    end

    // NOTE: the FIFO storage is reset because its head drives m_axis_tdata, which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else if (abort_run) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_tc_operand_stream_tx.sv
// Self-checking bench for tc_operand_stream_tx: SRAM model plus address/beat scoreboards
// checked every cycle at the falling edge.
`timescale 1ns/1ps
module tb_tc_operand_stream_tx;

    localparam int DW = 256;
    localparam int AW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_beats = '0;
    logic          abort = 1'b0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b0;

    tc_operand_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_beats     (num_beats),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         beat_q[$];
    logic [AW-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc;
    int n_reads, n_beats, n_done, n_last;
    int first_rd_cyc, first_vld_cyc, last_beat_cyc, done_cyc, busy_fall_cyc;
    logic prev_stall, prev_abort, prev_busy, s_busy;

    // Low byte is 0x90 + address (0xA0.. at 0x010..), address also placed in the top bits.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        logic [AW-1:0] lo;
        lo = a + AW'(10'h090);
        return {a, {(DW-AW-8){1'b0}}, lo[7:0]};
    endfunction

    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? word(mem_rd_addr) : {(DW/16){16'hDEAD}};
    end

    task automatic clear_sb();
        beat_q.delete();
        addr_q.delete();
        n_reads = 0; n_beats = 0; n_done = 0; n_last = 0;
        first_rd_cyc = -1; first_vld_cyc = -1; last_beat_cyc = -1;
        done_cyc = -1; busy_fall_cyc = -1;
        prev_stall = 1'b0; prev_abort = 1'b0;
    endtask

    task automatic expect_transfer(input logic [AW-1:0] base, input int n);
        beat_t b;
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + AW'(k);
            addr_q.push_back(a);
            b.data = word(a);
            b.last = (k == n - 1);
            beat_q.push_back(b);
        end
    endtask

    // One clock: sample and score outputs at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        cyc++;
        checks++;
        if (n_reads - n_beats > 2) begin
            errors++;
            $display("FAIL occupancy outstanding=%0d limit=2 cyc=%0d", n_reads - n_beats, cyc);
        end
        if (mem_rd_en === 1'b1) begin
            n_reads++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected addr=%h cyc=%0d", mem_rd_addr, cyc);
            end else begin
                exp_addr = addr_q.pop_front();
                if (mem_rd_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL rd_addr got=%h exp=%h cyc=%0d", mem_rd_addr, exp_addr, cyc);
                end
            end
        end
        if (prev_stall && !prev_abort) begin
            checks++;
            if (m_axis_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL tvalid_hold got=%b exp=1 cyc=%0d", m_axis_tvalid, cyc);
            end
        end
        if (m_axis_tvalid === 1'b1) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            checks++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected data=%h cyc=%0d", m_axis_tdata, cyc);
            end else begin
                if (m_axis_tdata !== beat_q[0].data) begin
                    errors++;
                    $display("FAIL tdata got=%h exp=%h cyc=%0d", m_axis_tdata, beat_q[0].data, cyc);
                end
                checks++;
                if (m_axis_tlast !== beat_q[0].last) begin
                    errors++;
                    $display("FAIL tlast got=%b exp=%b cyc=%0d", m_axis_tlast, beat_q[0].last, cyc);
                end
                if (m_axis_tready === 1'b1) begin
                    void'(beat_q.pop_front());
                    n_beats++;
                    last_beat_cyc = cyc;
                    if (m_axis_tlast === 1'b1) n_last++;
                end
            end
        end else begin
            checks++;
            if (m_axis_tlast !== 1'b0) begin
                errors++;
                $display("FAIL tlast_no_valid got=%b exp=0 cyc=%0d", m_axis_tlast, cyc);
            end
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (prev_busy && busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy  = (busy === 1'b1);
        s_busy     = busy;
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        prev_abort = abort;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [CW-1:0] n);
        base_addr = base;
        num_beats = n;
        start     = 1'b1;
        tick();
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        int n0 = n_done;
        while (n_done == n0 && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (n_done == n0) begin
            errors++;
            $display("FAIL %s_timeout done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        check_int({name, "_beats_left"}, beat_q.size(), 0);
        check_int({name, "_reads_left"}, addr_q.size(), 0);
        check_int({name, "_tlast_count"}, n_last, 1);
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({busy, done, mem_rd_en, m_axis_tvalid, m_axis_tlast} !== 5'b0
            || mem_rd_addr !== '0 || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b rd_en=%b tvalid=%b tlast=%b addr=%h data=%h exp=all zero",
                     name, busy, done, mem_rd_en, m_axis_tvalid, m_axis_tlast, mem_rd_addr, m_axis_tdata);
        end
    endtask

    task automatic test_reset();
        int i;
        clear_sb();
        prev_busy = 1'b0;
        tick();
        tick();
        #1 check_quiet("reset_initial");
        rst_n = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        expect_transfer(10'h020, 8);
        do_start(10'h020, 8'd8);
        i = 0;
        while (first_vld_cyc < 0 && i < 10) begin
            tick();
            i++;
        end
        check_int("reset_pre_tvalid_seen", (first_vld_cyc >= 0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, m_axis_tvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_async got busy=%b done=%b rd_en=%b tvalid=%b exp=0000",
                     busy, done, mem_rd_en, m_axis_tvalid);
        end
        clear_sb();
        prev_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_int("reset_no_done", n_done, 0);
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h000, 2);
        do_start(10'h000, 8'd2);
        wait_done("reset_restart", 20);
        check_drained("reset_restart");
    endtask

    task automatic test_basic();
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h010, 4);
        do_start(10'h010, 8'd4);
        wait_done("basic", 20);
        tick();
        check_int("basic_first_rd", first_rd_cyc - start_cyc, 1);
        check_int("basic_first_vld", first_vld_cyc - start_cyc, 3);
        check_int("basic_last_beat", last_beat_cyc - start_cyc, 6);
        check_int("basic_done", done_cyc - start_cyc, 7);
        check_int("basic_busy_fall", busy_fall_cyc - start_cyc, 8);
        check_int("basic_reads", n_reads, 4);
        check_int("basic_done_count", n_done, 1);
        check_drained("basic");
    endtask

    task automatic test_backpressure();
        int i = 0;
        clear_sb();
        expect_transfer(10'h040, 6);
        m_axis_tready = 1'b1;
        do_start(10'h040, 8'd6);
        while (n_done == 0 && i < 100) begin
            m_axis_tready = (i % 4 == 0) || (i % 4 == 3);
            tick();
            i++;
        end
        m_axis_tready = 1'b1;
        check_int("bp_done_count", n_done, 1);
        check_int("bp_beats", n_beats, 6);
        check_int("bp_reads", n_reads, 6);
        check_drained("bp");
    endtask

    task automatic test_zero_beats();
        clear_sb();
        do_start(10'h055, 8'd0);
        base_addr = 10'h066;
        num_beats = 8'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_int("zero_done_cycle", done_cyc - start_cyc, 1);
        check_int("zero_done_count", n_done, 1);
        check_int("zero_reads", n_reads, 0);
        check_int("zero_tvalid_seen", (first_vld_cyc >= 0) ? 1 : 0, 0);
        check_int("zero_busy_after", int'(s_busy), 0);
    endtask

    task automatic test_addr_wrap();
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h3FE, 4);
        do_start(10'h3FE, 8'd4);
        wait_done("wrap", 20);
        check_int("wrap_reads", n_reads, 4);
        check_drained("wrap");
    endtask

    task automatic test_abort();
        int i = 0;
        int abort_cyc;
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h080, 8);
        do_start(10'h080, 8'd8);
        while (n_beats < 3 && i < 20) begin
            tick();
            i++;
        end
        m_axis_tready = 1'b0;
        check_int("abort_pre_beats", n_beats, 3);
        for (int k = 0; k < 3; k++) tick();
        abort = 1'b1;
        tick();
        abort_cyc = cyc;
        abort = 1'b0;
        check_int("abort_no_tlast", n_last, 0);
        clear_sb();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check_int("abort_done_cycle", done_cyc - abort_cyc, 1);
        check_int("abort_done_count", n_done, 1);
        check_int("abort_beats_after", n_beats, 0);
        check_int("abort_reads_after", n_reads, 0);
        check_int("abort_busy_after", int'(s_busy), 0);
        clear_sb();
        expect_transfer(10'h100, 2);
        do_start(10'h100, 8'd2);
        wait_done("abort_next", 20);
        check_drained("abort_next");
    endtask

    task automatic test_abort_on_last();
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h200, 3);
        do_start(10'h200, 8'd3);
        for (int k = 0; k < 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_int("abort_last_beats", n_beats, 3);
        check_int("abort_last_done_cycle", done_cyc - start_cyc, 6);
        check_int("abort_last_done_count", n_done, 1);
        check_drained("abort_last");
    endtask

    task automatic test_back_to_back();
        clear_sb();
        m_axis_tready = 1'b1;
        expect_transfer(10'h300, 5);
        do_start(10'h300, 8'd5);
        wait_done("b2b_first", 30);
        expect_transfer(10'h123, 3);
        do_start(10'h123, 8'd3);
        wait_done("b2b_second", 30);
        check_int("b2b_beats", n_beats, 8);
        check_int("b2b_done_count", n_done, 2);
        check_int("b2b_tlast_count", n_last, 2);
        check_int("b2b_left", beat_q.size() + addr_q.size(), 0);
    endtask

    initial begin
        clear_sb();
        prev_busy = 1'b0;
        s_busy    = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_beats();
        test_addr_wrap();
        test_abort();
        test_abort_on_last();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
